temp_conv_arbiter: RTL and testbench
====================================

Name: temp_conv_arbiter

Overview:
- Shares one ROM-based temperature converter (sync ROM, address {unit, temperature}) between NUM_REQ requesters.
- Round-robin arbitration; one lookup in flight at a time.
- Accepts a request via valid/ready, drives the ROM address, waits the ROM latency, then returns the converted value with the requester ID on a valid/ready response port.
- Sits between converter clients (UI, display, logging) and the converter instance.

Parameters:
- NUM_REQ, 4: number of requesters, 1..8.
- DATA_WIDTH, 8: temperature width, in and out.
- ADDR_WIDTH, 9: ROM address width; must equal DATA_WIDTH+1 (elaboration error otherwise).
- ROM_LATENCY, 1: clock cycles from registered ROM address to valid rom_data_i, 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_temp_i  in  NUM_REQ*DATA_WIDTH  packed temperatures; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- req_unit_i  in  NUM_REQ  per-requester unit: 0 = C->F, 1 = F->C.
- rom_addr_o  out  ADDR_WIDTH  converter address, {unit, temp}, registered.
- rom_data_i  in  DATA_WIDTH  converter output.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  DATA_WIDTH  converted temperature.
- rsp_id_o  out  ID_W  granted requester index; ID_W = max(1, $clog2(NUM_REQ)).
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_ni low, async): state IDLE; req_ready_o = 0, rom_addr_o = 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_id_o = 0, busy_o = 0; last_grant = NUM_REQ-1, so the first search starts at index 0.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant g = first set bit searching last_grant+1, last_grant+2, ... with wrap.
  - req_ready_o[g] is combinationally high this cycle, only while in IDLE; the handshake completes on this edge.
  - On the edge: rom_addr_o <= {req_unit_i[g], temp_g}; rsp_id_o <= g; last_grant <= g; cnt <= ROM_LATENCY; go to LOOKUP.
  - If no valid bit is set, stay in IDLE with req_ready_o = 0.
- LOOKUP:
  - rom_addr_o held stable; cnt decrements each cycle.
  - In the cycle where cnt == 1: rsp_data_o <= rom_data_i; go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_id_o held.
  - On rsp_valid_o && rsp_ready_i: go to IDLE.
  - rsp_ready_i already high on the first RESP cycle gives a 1-cycle RESP.
- Latency: accept in cycle T -> rsp_valid_o first high in cycle T+1+ROM_LATENCY.
  - Throughput: one request per ROM_LATENCY+2 cycles with rsp_ready_i tied high.
- req_ready_o is all zeros in LOOKUP and RESP. Requesters hold valid and data until accepted.
- A requester may drop valid before it is granted; it is then simply not considered.
- Requester data is sampled only on the accept edge; later changes have no effect on the in-flight lookup.
- Backpressure: rsp_ready_i low holds RESP indefinitely with outputs stable; no new grants while held.
- Reset mid-transaction: the transaction is discarded; no response is issued.
- NUM_REQ = 1: rsp_id_o is always 0; the arbiter degenerates to a sequencer.
- No arithmetic on data. The address is a plain concatenation; out-of-table addresses return whatever the ROM holds.

Optional Feature:
- Macro: TEMP_CONV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and last_grant is unused.
- Undefined (default): round-robin as specified above.

Test Plan:
- Requester 0 only, temp 25, unit 0; ROM = real converter instance -> rsp_data_o = 77, rsp_id_o = 0, rsp_valid_o rises exactly 2 cycles after accept (ROM_LATENCY = 1).
- Requester 2 sends F 212, unit 1; then requester 3 sends F 32, unit 1 -> responses 100 (id 2) then 0 (id 3).
- All 4 requesters continuously valid, rsp_ready_i = 1 -> grant order 0, 1, 2, 3, 0, 1; one accept every 3 cycles. With TEMP_CONV_ARB_FIXED_PRIO_EN defined -> 0, 0, 0, ...
- Response backpressure: rsp_ready_i held low 5 cycles in RESP -> rsp_valid_o, rsp_data_o and rsp_id_o stable; req_ready_o = 0 throughout; on release, IDLE next cycle.
- rst_ni pulsed low during LOOKUP -> all outputs 0 immediately; no response afterwards. Next request accepted from index 0.
- ROM_LATENCY = 3, Celsius 100 unit 0 -> rsp_data_o = 212, rsp_valid_o first high in cycle T+4; rom_addr_o = 9'h064 stable through LOOKUP.

Source files
------------

// File: rtl/temp_conv_arbiter.sv
// temp_conv_arbiter: shares one synchronous temperature-conversion ROM
// between NUM_REQ requesters. It accepts one request at a time and drives the
// ROM address {unit, temperature}. After ROM_LATENCY cycles it returns the ROM
// output, tagged with the requester index, on a valid/ready response port.
// Optional build macro TEMP_CONV_ARB_FIXED_PRIO_EN selects fixed priority,
// where the lowest index wins. Without it the arbiter uses round-robin.
module temp_conv_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int ROM_LATENCY = 1,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_temp_i,
    input  logic [NUM_REQ-1:0]            req_unit_i,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic                          busy_o
);

    localparam int CNT_W = 3;

    // The address is a plain concatenation, so the widths must line up exactly.
    generate
        if (ADDR_WIDTH != DATA_WIDTH + 1) begin : g_addr_w_check
            $error("temp_conv_arbiter: ADDR_WIDTH must equal DATA_WIDTH+1");
        end
        if ((NUM_REQ < 1) || (NUM_REQ > 8)) begin : g_num_req_check
            $error("temp_conv_arbiter: NUM_REQ must be in 1..8");
        end
        if ((ROM_LATENCY < 1) || (ROM_LATENCY > 4)) begin : g_lat_check
            $error("temp_conv_arbiter: ROM_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_WIDTH-1:0]   rom_addr_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic [ID_W-1:0]         rsp_id_r;
    logic                    rsp_valid_r;
    logic                    busy_r;
`ifndef TEMP_CONV_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]         last_grant_r;
`endif

    logic                    grant_found_s;
    logic [ID_W-1:0]         grant_idx_s;
    logic [DATA_WIDTH-1:0]   grant_temp_s;
    logic                    grant_unit_s;
    logic [NUM_REQ-1:0]      req_ready_s;

    // Grant search. Each requester gets a rank and the valid requester with
    // the lowest rank wins. In round-robin the rank is the distance after the
    // last grant. In fixed priority the rank is the requester index.
    always_comb begin
        int rank_s;
        int best_rank_s;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_temp_s  = '0;
        grant_unit_s  = 1'b0;
        best_rank_s   = NUM_REQ;
        rank_s        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef TEMP_CONV_ARB_FIXED_PRIO_EN
            rank_s = i;
`else
            rank_s = (i + NUM_REQ - 1 - int'(last_grant_r)) % NUM_REQ;
`endif
            if (req_valid_i[i] && (rank_s < best_rank_s)) begin
                best_rank_s   = rank_s;
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(i);
                grant_temp_s  = req_temp_i[i*DATA_WIDTH +: DATA_WIDTH];
                grant_unit_s  = req_unit_i[i];
            end else begin
                best_rank_s   = best_rank_s;
            end
        end
    end

    // The accept strobe goes only to the winner, and only while idle.
    always_comb begin
        req_ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ST_IDLE) && grant_found_s && (grant_idx_s == ID_W'(i))) begin
                req_ready_s[i] = 1'b1;
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    // Sequencer: accept, wait out the ROM latency, then hold the response until it is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            rom_addr_r   <= '0;
            rsp_data_r   <= '0;
            rsp_id_r     <= '0;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifndef TEMP_CONV_ARB_FIXED_PRIO_EN
            last_grant_r <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        rom_addr_r   <= {grant_unit_s, grant_temp_s};
                        rsp_id_r     <= grant_idx_s;
`ifndef TEMP_CONV_ARB_FIXED_PRIO_EN
                        last_grant_r <= grant_idx_s;
`endif
                        cnt_r        <= CNT_W'(ROM_LATENCY);
                        busy_r       <= 1'b1;
                        state_r      <= ST_LOOKUP;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        rsp_data_r  <= rom_data_i;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r     <= ST_LOOKUP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_s;
    assign rom_addr_o  = rom_addr_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_data_o  = rsp_data_r;
    assign rsp_id_o    = rsp_id_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_temp_conv_arbiter.sv
// Directed bench for temp_conv_arbiter: one instance with ROM_LATENCY=1 and
// one with ROM_LATENCY=3, each backed by a behavioural conversion ROM.
module tb_temp_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, req_unit;
    logic [31:0] req_temp;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data, rsp_data;
    logic        rsp_valid, rsp_ready, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid3, req_ready3, req_unit3;
    logic [31:0] req_temp3;
    logic [8:0]  rom_addr3;
    logic [7:0]  rom_data3, rsp_data3, p1, p2;
    logic        rsp_valid3, rsp_ready3, busy3;
    logic [1:0]  rsp_id3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference converter table contents: C->F for unit 0, F->C for unit 1.
    function automatic logic [7:0] conv(input logic [8:0] a);
        int t;
        t = int'(a[7:0]);
        if (!a[8]) return 8'((t * 9) / 5 + 32);
        else if (t >= 32) return 8'(((t - 32) * 5) / 9);
        else return 8'd0;
    endfunction

    assign rom_data = conv(rom_addr);
    always @(posedge clk) begin
        p1 <= conv(rom_addr3);
        p2 <= p1;
    end
    assign rom_data3 = p2;

    temp_conv_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9), .ROM_LATENCY(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_temp_i(req_temp), .req_unit_i(req_unit), .rom_addr_o(rom_addr),
        .rom_data_i(rom_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .busy_o(busy));

    temp_conv_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9), .ROM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_temp_i(req_temp3), .req_unit_i(req_unit3), .rom_addr_o(rom_addr3),
        .rom_data_i(rom_data3), .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .rsp_data_o(rsp_data3), .rsp_id_o(rsp_id3), .busy_o(busy3));

    task automatic drive(input int k, input logic v, input logic [7:0] t, input logic u);
        req_valid[k]       = v;
        req_temp[k*8 +: 8] = t;
        req_unit[k]        = u;
    endtask

    // Counts falling edges until rsp_valid rises (bounded).
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++; if (rom_addr !== 9'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", rom_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n;
        @(negedge clk);
        drive(0, 1'b1, 8'd25, 1'b0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd25, 1'b0);
        checks++; if (rom_addr !== 9'h019) begin errors++; $display("FAIL single_addr got %h exp 019", rom_addr); end
        wait_rsp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", n); end
        checks++; if (rsp_data !== 8'd77) begin errors++; $display("FAIL single_data got %0d exp 77", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b valid %b exp 0 0", busy, rsp_valid); end
    endtask

    task automatic test_two_requesters();
        int         n;
        int         k_t    [2] = '{2, 3};
        logic [7:0] temp_t [2] = '{8'd212, 8'd32};
        logic [8:0] addr_t [2] = '{9'h1D4, 9'h120};
        logic [7:0] data_t [2] = '{8'd100, 8'd0};
        logic [3:0] rdy_t  [2] = '{4'b0100, 4'b1000};
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            drive(k_t[j], 1'b1, temp_t[j], 1'b1);
            #1;
            checks++; if (req_ready !== rdy_t[j]) begin errors++; $display("FAIL two_ready[%0d] got %b exp %b", j, req_ready, rdy_t[j]); end
            @(posedge clk); #1;
            drive(k_t[j], 1'b0, temp_t[j], 1'b1);
            checks++; if (rom_addr !== addr_t[j]) begin errors++; $display("FAIL two_addr[%0d] got %h exp %h", j, rom_addr, addr_t[j]); end
            wait_rsp(n);
            checks++; if (n !== 2) begin errors++; $display("FAIL two_latency[%0d] got %0d exp 2", j, n); end
            checks++; if (rsp_data !== data_t[j]) begin errors++; $display("FAIL two_data[%0d] got %0d exp %0d", j, rsp_data, data_t[j]); end
            checks++; if (rsp_id !== 2'(k_t[j])) begin errors++; $display("FAIL two_id[%0d] got %0d exp %0d", j, rsp_id, k_t[j]); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int g = 0;
        int idx_q [6];
        int cyc_q [6];
        int exp_idx;
        @(negedge clk);
        for (int k = 0; k < 4; k++) drive(k, 1'b1, 8'(10 * (k + 1)), 1'b0);
        for (int c = 0; c < 40 && g < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready !== 4'b0000) begin
                checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot got %b exp one-hot", req_ready); end
                idx_q[g] = 0;
                for (int b = 0; b < 4; b++) if (req_ready[b]) idx_q[g] = b;
                cyc_q[g] = c;
                g++;
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'd0, 1'b0);
        checks++; if (g !== 6) begin errors++; $display("FAIL rr_grant_count got %0d exp 6", g); end
        for (int i = 0; i < g; i++) begin
`ifdef TEMP_CONV_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % 4;
`endif
            checks++; if (idx_q[i] !== exp_idx) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, idx_q[i], exp_idx); end
            if (i > 0) begin
                checks++; if (cyc_q[i] - cyc_q[i-1] !== 3) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 3", i, cyc_q[i] - cyc_q[i-1]); end
            end
        end
        for (int w = 0; w < 20 && busy; w++) @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain got busy %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1, 1'b1, 8'd0, 1'b0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready got %b exp 0010", req_ready); end
        @(posedge clk); #1;
        drive(1, 1'b0, 8'd0, 1'b0);
        drive(2, 1'b1, 8'd77, 1'b0);
        wait_rsp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", n); end
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd32 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid %b data %0d id %0d ready %b busy %b exp 1 32 1 0000 1",
                         h, rsp_valid, rsp_data, rsp_id, req_ready, busy);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy %b valid %b exp 0 0", busy, rsp_valid); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_ready got %b exp 0100", req_ready); end
        drive(2, 1'b0, 8'd77, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_dropped got busy %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 8'd50, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd50, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_lookup got busy %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL rm_ctrl got busy %b valid %b ready %b exp 0 0 0000", busy, rsp_valid, req_ready); end
        checks++; if (rom_addr !== 9'h000 || rsp_data !== 8'd0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rm_data got addr %h data %0d id %0d exp 000 0 0", rom_addr, rsp_data, rsp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_rsp got activity %b exp 0", seen); end
        drive(0, 1'b1, 8'd60, 1'b0);
        drive(1, 1'b1, 8'd70, 1'b0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd60, 1'b0);
        drive(1, 1'b0, 8'd70, 1'b0);
        wait_rsp(n);
        checks++; if (n !== 2 || rsp_data !== 8'd140 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rm_after got lat %0d data %0d id %0d exp 2 140 0", n, rsp_data, rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int   n = 0;
        logic addr_ok = 1'b1;
        @(negedge clk);
        req_valid3[0] = 1'b1; req_temp3[7:0] = 8'd100; req_unit3[0] = 1'b0;
        #1;
        checks++; if (req_ready3 !== 4'b0001) begin errors++; $display("FAIL l3_ready got %b exp 0001", req_ready3); end
        @(posedge clk); #1;
        req_valid3[0] = 1'b0;
        while (!rsp_valid3 && n < 50) begin
            @(negedge clk);
            n++;
            if (rom_addr3 !== 9'h064) addr_ok = 1'b0;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL l3_latency got %0d exp 4", n); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL l3_addr_stable got %b exp 1", addr_ok); end
        checks++; if (rsp_data3 !== 8'd212 || rsp_id3 !== 2'd0) begin
            errors++; $display("FAIL l3_data got data %0d id %0d exp 212 0", rsp_data3, rsp_id3); end
        @(negedge clk);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL l3_idle got busy %b exp 0", busy3); end
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        rsp_ready3 = 1'b1;
        req_valid  = '0; req_temp  = '0; req_unit  = '0;
        req_valid3 = '0; req_temp3 = '0; req_unit3 = '0;
        test_reset();
        test_single();
        test_two_requesters();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
